// File: rtl/counter_time_prog.sv
// counter_time_prog: programmable game timer.
// A prescaler divides the board clock down to a count step. The count runs up
// toward LIMIT or down toward 0, can be paused (E low) and preloaded, and
// raises a sticky end_time flag on the final step. It never wraps.
// Optional feature macro: COUNTER_TIME_BCD_EN adds the bcd_tens/bcd_ones
// outputs, a combinational decimal split of tempo (requires LIMIT <= 99).
module counter_time_prog #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_FREQ = 1,
  parameter int WIDTH     = 4,
  parameter int LIMIT     = 10
) (
  input  logic             clkt,
  input  logic             R,
  input  logic             E,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] tempo,
  output logic             tick,
  output logic             end_time
`ifdef COUNTER_TIME_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  // Clock cycles per count step and the prescaler width needed to hold DIV-1.
  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] LIMIT_W  = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = '0;

  // Parameter sanity: refuse to elaborate a configuration that cannot work.
  generate
    if (DIV < 2) begin : g_div_check
      $error("counter_time_prog: CLK_FREQ/TICK_FREQ must be at least 2");
    end
    if ((LIMIT < 1) || (longint'(LIMIT) > ((longint'(1) << WIDTH) - 1))) begin : g_limit_check
      $error("counter_time_prog: LIMIT must lie in 1 .. 2**WIDTH-1");
    end
`ifdef COUNTER_TIME_BCD_EN
    if (LIMIT > 99) begin : g_bcd_check
      $error("counter_time_prog: LIMIT must not exceed 99 when the BCD outputs are enabled");
    end
`endif
  endgenerate

  // Operating mode is not stored separately; it follows from E and the
  // sticky end flag, so DONE can only be left through R or load.
  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;

  logic [PW-1:0]    prescaler_reg;
  logic [PW-1:0]    prescaler_next;
  logic [WIDTH-1:0] tempo_reg;
  logic [WIDTH-1:0] tempo_next;
  logic             tick_reg;
  logic             tick_next;
  logic             end_time_reg;
  logic             end_time_next;

  // Candidate values for a step in either direction.
  logic [WIDTH-1:0] tempo_inc;
  logic [WIDTH-1:0] tempo_dec;
  logic [WIDTH-1:0] load_clamped;
  logic             step_now;

  // Decode the current operating mode from the enable and the end flag.
  always_comb begin
    state = ST_PAUSE;
    if (end_time_reg) begin
      state = ST_DONE;
    end else if (E) begin
      state = ST_RUN;
    end
  end

  // Arithmetic helpers shared by the next-state logic.
  always_comb begin
    tempo_inc    = tempo_reg + ONE_W;
    tempo_dec    = tempo_reg - ONE_W;
    load_clamped = (load_val > LIMIT_W) ? LIMIT_W : load_val;
    step_now     = (state == ST_RUN) && (prescaler_reg == PRE_LAST);
  end

  // Next-state logic: load has priority over counting; reset lives in the register.
  always_comb begin
    prescaler_next = prescaler_reg;
    tempo_next     = tempo_reg;
    tick_next      = 1'b0;
    end_time_next  = end_time_reg;

    if (load) begin
      // Preload restarts the period and clears DONE, whatever the mode.
      tempo_next     = load_clamped;
      prescaler_next = '0;
      end_time_next  = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (step_now) begin
            prescaler_next = '0;
            tick_next      = 1'b1;
            if (!down) begin
              if (tempo_reg >= LIMIT_W) begin
                // Already at (or beyond) the limit: hold and finish.
                end_time_next = 1'b1;
              end else begin
                tempo_next = tempo_inc;
                if (tempo_inc == LIMIT_W) begin
                  end_time_next = 1'b1;
                end
              end
            end else begin
              if (tempo_reg == ZERO_W) begin
                // Nothing left to count down: hold at zero and finish.
                end_time_next = 1'b1;
              end else begin
                tempo_next = tempo_dec;
                if (tempo_dec == ZERO_W) begin
                  end_time_next = 1'b1;
                end
              end
            end
          end else begin
            prescaler_next = prescaler_reg + PRE_ONE;
          end
        end
        // PAUSE keeps the prescaler phase; DONE freezes everything.
        default: begin
          prescaler_next = prescaler_reg;
        end
      endcase
    end
  end

  // State register with synchronous reset; the reset value of tempo follows down.
  always_ff @(posedge clkt) begin
    if (R) begin
      prescaler_reg <= '0;
      tempo_reg     <= down ? LIMIT_W : ZERO_W;
      tick_reg      <= 1'b0;
      end_time_reg  <= 1'b0;
    end else begin
      prescaler_reg <= prescaler_next;
      tempo_reg     <= tempo_next;
      tick_reg      <= tick_next;
      end_time_reg  <= end_time_next;
    end
  end

  assign tempo    = tempo_reg;
  assign tick     = tick_reg;
  assign end_time = end_time_reg;

`ifdef COUNTER_TIME_BCD_EN
  logic [31:0] tempo_ext;

  // Decimal split for the 7-segment decoders, valid alongside tempo.
  always_comb begin
    tempo_ext = 32'(tempo_reg);
    bcd_tens  = 4'(tempo_ext / 32'd10);
    bcd_ones  = 4'(tempo_ext % 32'd10);
  end
`endif

endmodule

// File: tb/tb_counter_time_prog.sv
// Directed testbench for counter_time_prog with DIV=4, WIDTH=4, LIMIT=10.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// so each sample reflects the edge just taken.
module tb_counter_time_prog;

  logic       clkt;
  logic       R;
  logic       E;
  logic       down;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] tempo;
  logic       tick;
  logic       end_time;
`ifdef COUNTER_TIME_BCD_EN
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
`endif

  int checks = 0;
  int errors = 0;

  counter_time_prog #(
    .CLK_FREQ (4),
    .TICK_FREQ(1),
    .WIDTH    (4),
    .LIMIT    (10)
  ) dut (
    .clkt    (clkt),
    .R       (R),
    .E       (E),
    .down    (down),
    .load    (load),
    .load_val(load_val),
    .tempo   (tempo),
    .tick    (tick),
    .end_time(end_time)
`ifdef COUNTER_TIME_BCD_EN
    ,
    .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones)
`endif
  );

  initial clkt = 1'b0;
  always #5 clkt = ~clkt;

  task automatic step_clk();
    @(posedge clkt);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b1; down = 1'b0; E = 1'b0; load = 1'b0; load_val = 4'd0;
    step_clk();
    checks++;
    if (tempo !== 4'd0) begin errors++; $display("FAIL reset_up_tempo: got %0d expected 0", tempo); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++;
    if (end_time !== 1'b0) begin errors++; $display("FAIL reset_end: got %b expected 0", end_time); end
    down = 1'b1;
    step_clk();
    checks++;
    if (tempo !== 4'd10) begin errors++; $display("FAIL reset_down_tempo: got %0d expected 10", tempo); end
    R = 1'b0;
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_up_count();
    int exp_tempo;
    logic exp_tick;
    logic exp_end;
    R = 1'b1; down = 1'b0; E = 1'b0;
    step_clk();
    R = 1'b0; E = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      step_clk();
      exp_tempo = (c / 4 > 10) ? 10 : c / 4;
      exp_tick  = ((c % 4) == 0) && (c <= 40);
      exp_end   = (c >= 40);
      checks++;
      if (tempo !== 4'(exp_tempo)) begin errors++; $display("FAIL up_tempo cycle %0d: got %0d expected %0d", c, tempo, exp_tempo); end
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL up_tick cycle %0d: got %b expected %b", c, tick, exp_tick); end
      checks++;
      if (end_time !== exp_end) begin errors++; $display("FAIL up_end cycle %0d: got %b expected %b", c, end_time, exp_end); end
`ifdef COUNTER_TIME_BCD_EN
      checks++;
      if ((bcd_tens !== 4'(exp_tempo / 10)) || (bcd_ones !== 4'(exp_tempo % 10))) begin
        errors++;
        $display("FAIL up_bcd cycle %0d: got %0d%0d expected %0d", c, bcd_tens, bcd_ones, exp_tempo);
      end
`endif
    end
    E = 1'b0;
    $display("test_up_count done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_down_count();
    int exp_tempo;
    logic exp_tick;
    logic exp_end;
    R = 1'b1; down = 1'b1; E = 1'b0;
    step_clk();
    checks++;
    if (tempo !== 4'd10) begin errors++; $display("FAIL down_start: got %0d expected 10", tempo); end
    R = 1'b0; E = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      step_clk();
      exp_tempo = (c >= 40) ? 0 : 10 - c / 4;
      exp_tick  = ((c % 4) == 0) && (c <= 40);
      exp_end   = (c >= 40);
      checks++;
      if (tempo !== 4'(exp_tempo)) begin errors++; $display("FAIL down_tempo cycle %0d: got %0d expected %0d", c, tempo, exp_tempo); end
      checks++;
      if (tick !== exp_tick) begin errors++; $display("FAIL down_tick cycle %0d: got %b expected %b", c, tick, exp_tick); end
      checks++;
      if (end_time !== exp_end) begin errors++; $display("FAIL down_end cycle %0d: got %b expected %b", c, end_time, exp_end); end
    end
    E = 1'b0;
    $display("test_down_count done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_pause();
    R = 1'b1; down = 1'b0; E = 1'b0;
    step_clk();
    R = 1'b0; E = 1'b1;
    repeat (6) step_clk();
    checks++;
    if (tempo !== 4'd1) begin errors++; $display("FAIL pause_pre: got %0d expected 1", tempo); end
    E = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step_clk();
      checks++;
      if ((tempo !== 4'd1) || (tick !== 1'b0) || (end_time !== 1'b0)) begin
        errors++;
        $display("FAIL pause_hold cycle %0d: got tempo=%0d tick=%b end=%b expected 1/0/0", c, tempo, tick, end_time);
      end
    end
    E = 1'b1;
    step_clk();
    checks++;
    if ((tempo !== 4'd1) || (tick !== 1'b0)) begin errors++; $display("FAIL pause_resume1: got tempo=%0d tick=%b expected 1/0", tempo, tick); end
    step_clk();
    checks++;
    if ((tempo !== 4'd2) || (tick !== 1'b1)) begin errors++; $display("FAIL pause_resume2: got tempo=%0d tick=%b expected 2/1", tempo, tick); end
    E = 1'b0;
    $display("test_pause done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_gap();
    R = 1'b1; down = 1'b0; E = 1'b0;
    step_clk();
    R = 1'b0; E = 1'b1;
    repeat (3) step_clk();
    E = 1'b0;
    step_clk();
    checks++;
    if ((tempo !== 4'd0) || (tick !== 1'b0)) begin errors++; $display("FAIL gap_hold: got tempo=%0d tick=%b expected 0/0", tempo, tick); end
    E = 1'b1;
    step_clk();
    checks++;
    if ((tempo !== 4'd1) || (tick !== 1'b1)) begin errors++; $display("FAIL gap_step: got tempo=%0d tick=%b expected 1/1", tempo, tick); end
    E = 1'b0;
    $display("test_single_gap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_load_clamp();
    R = 1'b1; down = 1'b0; E = 1'b0;
    step_clk();
    R = 1'b0; E = 1'b1;
    repeat (40) step_clk();
    checks++;
    if ((end_time !== 1'b1) || (tempo !== 4'd10)) begin errors++; $display("FAIL load_done: got tempo=%0d end=%b expected 10/1", tempo, end_time); end
    load = 1'b1; load_val = 4'd13;
    step_clk();
    checks++;
    if (tempo !== 4'd10) begin errors++; $display("FAIL load_clamp_tempo: got %0d expected 10", tempo); end
    checks++;
    if ((end_time !== 1'b0) || (tick !== 1'b0)) begin errors++; $display("FAIL load_clamp_flags: got end=%b tick=%b expected 0/0", end_time, tick); end
    load = 1'b0;
    repeat (2) step_clk();
    checks++;
    if ((tempo !== 4'd10) || (tick !== 1'b0)) begin errors++; $display("FAIL load_midrun: got tempo=%0d tick=%b expected 10/0", tempo, tick); end
    load = 1'b1; load_val = 4'd7;
    step_clk();
    checks++;
    if ((tempo !== 4'd7) || (end_time !== 1'b0)) begin errors++; $display("FAIL load7: got tempo=%0d end=%b expected 7/0", tempo, end_time); end
    load = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step_clk();
      checks++;
      if ((tempo !== ((c == 4) ? 4'd8 : 4'd7)) || (tick !== (c == 4))) begin
        errors++;
        $display("FAIL load7_run cycle %0d: got tempo=%0d tick=%b expected %0d/%b", c, tempo, tick, (c == 4) ? 8 : 7, (c == 4));
      end
    end
    E = 1'b0;
    $display("test_load_clamp done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_priority_guard();
    R = 1'b1; load = 1'b1; load_val = 4'd5; down = 1'b0; E = 1'b1;
    step_clk();
    checks++;
    if (tempo !== 4'd0) begin errors++; $display("FAIL prio_up: got %0d expected 0", tempo); end
    down = 1'b1;
    step_clk();
    checks++;
    if (tempo !== 4'd10) begin errors++; $display("FAIL prio_down: got %0d expected 10", tempo); end
    R = 1'b0; load = 1'b1; load_val = 4'd0;
    step_clk();
    checks++;
    if ((tempo !== 4'd0) || (end_time !== 1'b0)) begin errors++; $display("FAIL guard_load0: got tempo=%0d end=%b expected 0/0", tempo, end_time); end
    load = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step_clk();
      checks++;
      if ((tempo !== 4'd0) || (tick !== (c == 4)) || (end_time !== (c >= 4))) begin
        errors++;
        $display("FAIL guard_down cycle %0d: got tempo=%0d tick=%b end=%b expected 0/%b/%b", c, tempo, tick, end_time, (c == 4), (c >= 4));
      end
    end
    E = 1'b0;
    $display("test_priority_guard done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_direction_change();
    R = 1'b1; down = 1'b0; E = 1'b0;
    step_clk();
    R = 1'b0; E = 1'b1;
    repeat (10) step_clk();
    checks++;
    if (tempo !== 4'd2) begin errors++; $display("FAIL dir_pre: got %0d expected 2", tempo); end
    down = 1'b1;
    step_clk();
    checks++;
    if ((tempo !== 4'd2) || (tick !== 1'b0)) begin errors++; $display("FAIL dir_wait: got tempo=%0d tick=%b expected 2/0", tempo, tick); end
    step_clk();
    checks++;
    if ((tempo !== 4'd1) || (tick !== 1'b1)) begin errors++; $display("FAIL dir_step: got tempo=%0d tick=%b expected 1/1", tempo, tick); end
    E = 1'b0;
    $display("test_direction_change done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    R = 1'b1; E = 1'b0; down = 1'b0; load = 1'b0; load_val = 4'd0;
    test_reset();
    test_up_count();
    test_down_count();
    test_pause();
    test_single_gap();
    test_load_clamp();
    test_priority_guard();
    test_direction_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_time_prog.md
# counter_time_prog

Parametrised game timer, successor to the fixed 4-bit time counter used in the game datapath. A prescaler derived from the board clock generates a time tick. The block counts up to or down from a programmable limit, can be paused and preloaded, and raises `end_time` when the limit is reached. It sits in the datapath between the FSM control strobes (`R`, `E`) and the 7-segment decoders.

## Interface
- `CLK_FREQ`, default 50_000_000: input clock frequency in Hz.
- `TICK_FREQ`, default 1: tick rate in Hz. `DIV = CLK_FREQ/TICK_FREQ` must be ≥ 2.
- `WIDTH`, default 4: width of `tempo`.
- `LIMIT`, default 10: terminal count. Requires 1 ≤ LIMIT ≤ 2^WIDTH−1.

Ports:
- `clkt` in 1: clock; the only clock.
- `R` in 1: reset; synchronous, active-high.
- `E` in 1: count enable; low pauses the count.
- `down` in 1: direction; 0 = count up toward LIMIT, 1 = count down toward 0.
- `load` in 1: synchronous preload strobe.
- `load_val` in WIDTH: preload value.
- `tempo` out WIDTH: current count, registered.
- `tick` out 1: one-cycle pulse on every count step, registered.
- `end_time` out 1: sticky terminal flag, registered.

## Operation
- Priority on each edge: R > load > count.
- Reset (R=1):
  - prescaler ← 0, tick ← 0, end_time ← 0.
  - tempo ← 0 if down=0; tempo ← LIMIT if down=1 (`down` sampled at that edge).
- Load (load=1, R=0):
  - tempo ← min(load_val, LIMIT).
  - prescaler ← 0, tick ← 0, end_time ← 0.
  - Load is accepted even while end_time=1.
- States, derived from E and end_time:
  - PAUSE (E=0, end_time=0): prescaler, tempo and end_time hold; tick=0. The prescaler is not cleared.
  - RUN (E=1, end_time=0): the prescaler increments each cycle.
  - DONE (end_time=1): everything frozen; tick=0. Only R or load leaves DONE.
- Step: on the edge where the block is in RUN and prescaler = DIV−1:
  - prescaler ← 0, tick ← 1.
  - Up: tempo ← tempo+1. If the new value = LIMIT, end_time ← 1 on the same edge.
  - Down: tempo ← tempo−1. If the new value = 0, end_time ← 1 on the same edge.
  - Guard, up with tempo ≥ LIMIT: tempo holds, end_time ← 1.
  - Guard, down with tempo = 0: tempo holds, end_time ← 1.
  - No wrap-around ever occurs.
- Otherwise tick ← 0.
- A change of `down` mid-count takes effect at the next step. The prescaler phase is kept.
- Arithmetic is unsigned and WIDTH bits. The prescaler is ⌈log2(DIV)⌉ bits.

## Timing
- First step occurs DIV cycles of RUN after reset or load.
- Subsequent steps occur every DIV cycles of RUN. PAUSE cycles do not count.
- tempo, tick and end_time change on the same edge; there is zero added latency.
- end_time rises on the edge of the final step and stays high until R or load.
- An R or load asserted mid-period discards the partial prescaler count.
- E toggling for a single cycle delays the next step by exactly one cycle.

## Configuration
- Macro `COUNTER_TIME_BCD_EN`.
- Defined:
  - Adds outputs `bcd_tens` (4 bits) and `bcd_ones` (4 bits). They are the combinational decimal split of `tempo` and valid in the same cycle as `tempo`.
  - LIMIT must be ≤ 99; elaboration fails otherwise.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Test plan
Bench parameters: CLK_FREQ=4, TICK_FREQ=1 (DIV=4), WIDTH=4, LIMIT=10.

1. Up count: R for 1 cycle with down=0, then E=1 held. Required:
   - tick pulses at cycles 4, 8, …, 40.
   - tempo reaches 10 at cycle 40 with end_time=1 on the same edge.
   - tempo stays 10 and tick stays 0 afterwards.
2. Down count: R with down=1 gives tempo=10. Then E=1: tempo reaches 0 after 40 cycles, end_time=1, no wrap to 15.
3. Pause: E=1 for 6 cycles, E=0 for 10 cycles, then E=1. Required:
   - tempo=1 during the pause.
   - next step occurs exactly 2 RUN cycles after E returns high.
4. Load and clamp:
   - In DONE, load with load_val=13: tempo=10, end_time=0.
   - Load with load_val=7: tempo=7, prescaler restarts, first step after 4 RUN cycles.
5. Priority and guard:
   - R and load asserted together: reset result wins.
   - Load 0 with down=1, then run: first step holds tempo=0 and sets end_time.
6. With `COUNTER_TIME_BCD_EN` defined, LIMIT=12, up count to 12: bcd_tens=1 and bcd_ones=2 in the same cycle tempo=12.
